// File: rtl/spi_pkg.sv
// Shared types and constants for the burst-capable SPI slave controller.
package spi_pkg;

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        GET_HDR      = 4'd1,
        GOT          = 4'd2,
        READ_WAIT    = 4'd3,
        READ_LOAD    = 4'd4,
        READ_OUT     = 4'd5,
        WRITE_IN     = 4'd6,
        WRITE_COMMIT = 4'd7,
        WRITE_INC    = 4'd8
    } state_t;

    localparam logic RW_READ = 1'b1;

    // States in which qualified SCLK edges advance the bit counter.
    function automatic logic is_shift_state(input state_t s);
        return (s == GET_HDR) || (s == READ_OUT) || (s == WRITE_IN);
    endfunction

endpackage

// File: rtl/spi_slave_fsm_burst_if.sv
// Handshake/strobe bundle between the SPI input conditioner/datapath and the controller FSM.
interface spi_slave_fsm_burst_if #(
    parameter int unsigned BURST_W = 8
);
    logic               cs;
    logic               sclk_pos;
    logic               rw;
    logic               sr_we;
    logic               dm_we;
    logic               addr_we;
    logic               addr_inc;
    logic               miso_en;
    logic               busy;
    logic [3:0]         state;
    logic [BURST_W-1:0] burst_count;

    modport slave (
        input  cs, sclk_pos, rw,
        output sr_we, dm_we, addr_we, addr_inc, miso_en, busy, state, burst_count
    );

    modport master (
        output cs, sclk_pos, rw,
        input  sr_we, dm_we, addr_we, addr_inc, miso_en, busy, state, burst_count
    );
endinterface

// File: rtl/spi_bit_counter.sv
// Counts qualified SCLK rising edges and flags the edge that completes a field.
module spi_bit_counter #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    // Clear dominates the edge enable so a field always starts from zero.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // High on the edge that brings the count up to the terminal value.
    assign o_last = i_en && !i_clr && ((r_cnt + 1'b1) == i_term);

endmodule

// File: rtl/spi_slave_fsm_burst.sv
// SPI slave control FSM: header decode then unbounded auto-incrementing burst until CS rises.
module spi_slave_fsm_burst
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 7,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned BURST_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_slave_fsm_burst_if.slave  bus
);

    state_t             r_state;
    logic               r_sr_we;
    logic               r_dm_we;
    logic               r_addr_we;
    logic               r_addr_inc;
    logic               r_miso_en;
    logic               r_busy;
    logic [BURST_W-1:0] r_burst;

    logic               w_cnt_clr;
    logic               w_last;
    logic [CNT_W-1:0]   w_term;

    // Counter is held at zero outside shifting states, so every entry starts a fresh field.
    assign w_cnt_clr = !is_shift_state(r_state);
    assign w_term    = (r_state == GET_HDR) ? CNT_W'(ADDR_BITS + 1) : CNT_W'(DATA_BITS);

    spi_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_cnt_clr),
        .i_en   (bus.sclk_pos),
        .i_term (w_term),
        .o_last (w_last)
    );

    // Strobes are registered on the edge that enters their state, so a CS abort
    // seen in a state cancels only what the following state would have driven;
    // dm_we is already out during WRITE_COMMIT and therefore survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sr_we    <= 1'b0;
            r_dm_we    <= 1'b0;
            r_addr_we  <= 1'b0;
            r_addr_inc <= 1'b0;
            r_miso_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_burst    <= '0;
        end else begin
            r_sr_we    <= 1'b0;
            r_dm_we    <= 1'b0;
            r_addr_we  <= 1'b0;
            r_addr_inc <= 1'b0;
            if (r_state != IDLE && bus.cs) begin
                r_state   <= IDLE;
                r_miso_en <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_miso_en <= 1'b0;
                        if (!bus.cs) begin
                            r_state <= GET_HDR;
                            r_busy  <= 1'b1;
                            r_burst <= '0;
                        end
                    end
                    GET_HDR: begin
                        if (w_last) begin
                            r_state   <= GOT;
                            r_addr_we <= 1'b1;
                        end
                    end
                    GOT: begin
                        r_state <= (bus.rw == RW_READ) ? READ_WAIT : WRITE_IN;
                    end
                    READ_WAIT: begin
                        r_state <= READ_LOAD;
                        r_sr_we <= 1'b1;
                    end
                    READ_LOAD: begin
                        r_state   <= READ_OUT;
                        r_miso_en <= 1'b1;
                    end
                    READ_OUT: begin
                        if (w_last) begin
                            r_state    <= READ_WAIT;
                            r_miso_en  <= 1'b0;
                            r_addr_inc <= 1'b1;
                            if (r_burst != '1) r_burst <= r_burst + 1'b1;
                        end
                    end
                    WRITE_IN: begin
                        if (w_last) begin
                            r_state <= WRITE_COMMIT;
                            r_dm_we <= 1'b1;
                        end
                    end
                    WRITE_COMMIT: begin
                        r_state    <= WRITE_INC;
                        r_addr_inc <= 1'b1;
                        if (r_burst != '1) r_burst <= r_burst + 1'b1;
                    end
                    WRITE_INC: begin
                        r_state <= WRITE_IN;
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_miso_en <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sr_we       = r_sr_we;
    assign bus.dm_we       = r_dm_we;
    assign bus.addr_we     = r_addr_we;
    assign bus.addr_inc    = r_addr_inc;
    assign bus.miso_en     = r_miso_en;
    assign bus.busy        = r_busy;
    assign bus.state       = r_state;
    assign bus.burst_count = r_burst;

endmodule

// File: doc/spi_slave_fsm_burst.md
Name: spi_slave_fsm_burst

Overview:
Parametrised control FSM for the SPI slave datapath, successor to the fixed 8-bit single-transfer controller. It counts qualified SCLK rising-edge pulses rather than system clocks, and decodes a header of ADDR_BITS address bits plus one R/W bit. It then services an unbounded burst of DATA_BITS-wide words with address auto-increment until CS deasserts. It drives the same strobes as before (sr_we, dm_we, addr_we, miso_en) plus addr_inc for the address latch/counter.

Parameters:
ADDR_BITS, 7, address field width in header (header = ADDR_BITS+1 bits, R/W last)
DATA_BITS, 8, payload word width
CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > max(ADDR_BITS+1, DATA_BITS)
BURST_W, 8, burst word counter width; saturates at all-ones

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cs  input  1  chip select, active-low, already synchronised to clk
sclk_pos  input  1  one-clk pulse per SCLK rising edge (from input conditioner)
rw  input  1  shift-register LSB; sampled in GOT; 1 = read, 0 = write
sr_we  output  1  parallel-load shift register from data memory
dm_we  output  1  write shift-register contents to data memory
addr_we  output  1  load address latch from shift register
addr_inc  output  1  increment address latch by 1 (wraps modulo 2**ADDR_BITS)
miso_en  output  1  enable MISO tristate driver
busy  output  1  high in every state except IDLE
state  output  4  current state encoding, for debug
burst_count  output  BURST_W  words completed in current transaction

Behaviour:
- Reset, and the power-up state: state=IDLE, bit_cnt=0, burst_count=0, all strobes 0, busy=0. Reset overrides all other inputs.
- All strobes are registered, single-cycle pulses; default 0 each cycle. miso_en is a level held through READ_OUT.
- bit_cnt increments only on cycles where sclk_pos=1. It clears on entry to GET_HDR, READ_OUT and WRITE_IN.
- States and transitions:
  - IDLE: on cs=0 -> GET_HDR.
  - GET_HDR: when bit_cnt reaches ADDR_BITS+1 -> GOT.
  - GOT: assert addr_we for 1 cycle. If rw=1 -> READ_WAIT, else -> WRITE_IN.
  - READ_WAIT: 1 cycle for memory read latency -> READ_LOAD.
  - READ_LOAD: assert sr_we for 1 cycle -> READ_OUT.
  - READ_OUT: miso_en=1. When bit_cnt reaches DATA_BITS: assert addr_inc, increment burst_count, then -> READ_WAIT (next word).
  - WRITE_IN: when bit_cnt reaches DATA_BITS -> WRITE_COMMIT.
  - WRITE_COMMIT: assert dm_we for 1 cycle, then -> WRITE_INC.
  - WRITE_INC: assert addr_inc, increment burst_count, then -> WRITE_IN.
- cs=1 in any non-IDLE state forces next state IDLE and suppresses sr_we, addr_we, addr_inc and miso_en that cycle.
- Exception to the above: dm_we in WRITE_COMMIT is still asserted, because the word is complete. A partial word in WRITE_IN is discarded, with no dm_we.
- burst_count clears on IDLE->GET_HDR. It holds its value in IDLE for readback and saturates at 2**BURST_W-1.
- sclk_pos arriving in GOT, READ_WAIT, READ_LOAD, WRITE_COMMIT or WRITE_INC is ignored. The upstream SPI clock must leave at least 3 clk periods between the last bit of a word and the next edge.
- Address wrap: addr_inc at address all-ones wraps to 0 (performed in the latch; the FSM only pulses).
- Latency: addr_we is asserted 1 clk after the header's final sclk_pos. For reads, sr_we is asserted 3 clks after the header's final sclk_pos.
- Undefined state encodings -> IDLE on the next clk.

Decomposition:
- Shared package spi_pkg: state enum (IDLE, GET_HDR, GOT, READ_WAIT, READ_LOAD, READ_OUT, WRITE_IN, WRITE_COMMIT, WRITE_INC) with a 4-bit encoding, and RW_READ=1.
- One natural sub-module, spi_bit_counter: a CNT_W-bit counter with clear, enable (sclk_pos) and terminal-compare inputs. It is instantiated once, and its compare value is muxed between ADDR_BITS+1 and DATA_BITS by state.

Test Plan:
- Reset mid-READ_OUT: assert reset with cs=0 -> next clk state=IDLE, miso_en=0, burst_count=0.
- Single write, defaults: cs low, 8 header pulses with rw=0, then 8 data pulses -> addr_we exactly once, dm_we exactly once 1 clk after the 16th pulse. addr_inc fires once and burst_count=1 after cs rises.
- Read burst of 3 words, ADDR_BITS=7, start address 0x7F -> sr_we pulses 3 times, addr_inc 3 times (latch wraps 0x7F->0x00->0x01), burst_count=3, miso_en high only during READ_OUT.
- Abort during write: cs rises after 5 of 8 data pulses -> no dm_we, state=IDLE the next clk, burst_count=0.
- cs rises in the same clk as WRITE_COMMIT -> dm_we still pulses, addr_inc does not, state=IDLE.
- Parameter sweep ADDR_BITS=15, DATA_BITS=16: header completes on the 16th pulse and a word completes on the 16th data pulse. Also check burst_count saturation with BURST_W=2 after 5 words -> 3.
